// File: rtl/reg_alu_pkg.sv
// Shared opcodes, FSM encoding and default widths for the register-file
// execution sequencer.
package reg_alu_pkg;
  localparam int DEF_DW = 16;
  localparam int DEF_AW = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Shifts and multiply run on the iterative datapath; the rest finish in one EXEC cycle.
  function automatic logic is_iter(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
  endfunction
endpackage

// File: rtl/reg_alu_seq_if.sv
// Request handshake plus register-file read/write ports of the sequencer.
interface reg_alu_seq_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] src_a;
  logic [AW-1:0] src_b;
  logic [AW-1:0] dst;
  logic [DW-1:0] R;
  logic [DW-1:0] S;
  logic [AW-1:0] R_Adr;
  logic [AW-1:0] S_Adr;
  logic [AW-1:0] W_Adr;
  logic [DW-1:0] W;
  logic          we;
  logic          busy;
  logic          done;
  logic          zero;
  logic          carry;

  modport master (
    output start, op, src_a, src_b, dst, R, S,
    input  R_Adr, S_Adr, W_Adr, W, we, busy, done, zero, carry
  );

  modport slave (
    input  start, op, src_a, src_b, dst, R, S,
    output R_Adr, S_Adr, W_Adr, W, we, busy, done, zero, carry
  );
endinterface

// File: rtl/reg_alu_iter.sv
// Iterative datapath: one-bit-per-cycle shifts and a 16-step shift-add multiply.
// result is the value after the current cycle's step, so the caller can
// register it on the same edge that ends the iteration.
module reg_alu_iter
  import reg_alu_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    mode,
  output logic [DW-1:0] result,
  output logic          last
);
  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] acc, acc_nxt;
  logic [DW-1:0] mcand, mcand_nxt;
  logic [DW-1:0] mplr;
  logic [CW-1:0] cnt;
  logic [2:0]    mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      cnt    <= '0;
      mode_q <= OP_ADD;
    end else if (load) begin
      mode_q <= mode;
      if (mode == OP_MUL) begin
        acc   <= '0;
        mcand <= a;
        mplr  <= b;
        cnt   <= CW'(DW);
      end else begin
        acc   <= a;
        mcand <= '0;
        mplr  <= '0;
        cnt   <= CW'(b[3:0]);
      end
    end else begin
      acc   <= acc_nxt;
      mcand <= mcand_nxt;
      mplr  <= mplr >> 1;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    acc_nxt   = acc;
    mcand_nxt = mcand;
    if (cnt != '0) begin
      if (mode_q == OP_MUL) begin
        acc_nxt   = acc + (mplr[0] ? mcand : '0);
        mcand_nxt = mcand << 1;
      end else if (mode_q == OP_SHL) begin
        acc_nxt = acc << 1;
      end else begin
        acc_nxt = acc >> 1;
      end
    end
  end

  // A zero shift count still spends one EXEC cycle and passes A through.
  assign result = acc_nxt;
  assign last   = (cnt <= CW'(1));
endmodule

// File: rtl/reg_alu_seq.sv
// Multi-cycle execution sequencer: reads two registers, runs a single-cycle
// ALU op or an iterative shift/multiply, and writes the result back.
module reg_alu_seq
  import reg_alu_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic clk,
  input  logic reset,
  reg_alu_seq_if.slave bus
);
  state_t        state, nxt;
  logic [2:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] r_adr_q, s_adr_q, w_adr_q;
  logic [DW-1:0] a_q, b_q, w_q;
  logic          zero_q, carry_q;

  logic [DW:0]   alu_res;
  logic [DW-1:0] res;
  logic          res_carry;
  logic [DW-1:0] iter_res;
  logic          iter_last;
  logic          exec_end;

  reg_alu_iter #(.DW(DW)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (state == ST_READ),
    .a      (bus.R),
    .b      (bus.S),
    .mode   (op_q),
    .result (iter_res),
    .last   (iter_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  assign exec_end = !is_iter(op_q) || iter_last;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (bus.start) nxt = ST_READ;
      ST_READ: nxt = ST_EXEC;
      ST_EXEC: if (exec_end) nxt = ST_WB;
      ST_WB:   nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state != ST_IDLE);
    bus.we    = (state == ST_WB);
    bus.done  = (state == ST_WB);
    bus.R_Adr = r_adr_q;
    bus.S_Adr = s_adr_q;
    bus.W_Adr = w_adr_q;
    bus.W     = w_q;
    bus.zero  = zero_q;
    bus.carry = carry_q;
  end

  // ADD/SUB run one bit wider so bit DW is the carry, or the borrow for A < B.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  alu_res = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  alu_res = {1'b0, a_q & b_q};
      OP_OR:   alu_res = {1'b0, a_q | b_q};
      OP_XOR:  alu_res = {1'b0, a_q ^ b_q};
      default: alu_res = '0;
    endcase
  end

  assign res       = is_iter(op_q) ? iter_res : alu_res[DW-1:0];
  assign res_carry = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_res[DW] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_ADD;
      dst_q   <= '0;
      r_adr_q <= '0;
      s_adr_q <= '0;
      w_adr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          op_q    <= bus.op;
          dst_q   <= bus.dst;
          r_adr_q <= bus.src_a;
          s_adr_q <= bus.src_b;
        end
        ST_READ: begin
          a_q <= bus.R;
          b_q <= bus.S;
        end
        ST_EXEC: if (exec_end) begin
          w_adr_q <= dst_q;
          w_q     <= res;
          zero_q  <= (res == '0);
          carry_q <= res_carry;
        end
        default: ;
      endcase
    end
  end
endmodule
